// File: rtl/xv_blank_monitor_pkg.sv
// rtl/xv_blank_monitor_pkg.sv - shared FSM encodings, error bit indices and counter widths
package xv_blank_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_WAIT_P1 = 2'd2,
    ST_PHASE   = 2'd3
  } state_t;

  localparam int ERR_ORDER_BIT = 0;
  localparam int ERR_DWELL_BIT = 1;

  localparam int CNT_W      = 10;
  localparam int DWELL_W    = 6;
  localparam int NUM_PHASES = 8;

  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [DWELL_W-1:0] DWELL_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/xv_dwell_timer.sv
// rtl/xv_dwell_timer.sv - per-phase dwell counter with saturation and tolerance window compare
module xv_dwell_timer
  import xv_blank_monitor_pkg::*;
#(
  parameter int STATE_WIDTH = 8,
  parameter int DWELL_TOL   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic run,
  input  logic clear,
  output logic out_of_window
);

  localparam logic [DWELL_W-1:0] DWELL_LO = DWELL_W'(STATE_WIDTH - DWELL_TOL);
  localparam logic [DWELL_W-1:0] DWELL_HI = DWELL_W'(STATE_WIDTH + DWELL_TOL);

  logic [DWELL_W-1:0] dwell;

  // Restart loads 1 because the cycle that reveals the new code is already part of its dwell.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell <= '0;
    end else if (clear) begin
      dwell <= '0;
    end else if (restart) begin
      dwell <= DWELL_W'(1);
    end else if (run && (dwell != DWELL_MAX)) begin
      dwell <= dwell + 1'b1;
    end
  end

  assign out_of_window = (dwell < DWELL_LO) || (dwell > DWELL_HI);

endmodule

// File: rtl/xv_blank_monitor.sv
// rtl/xv_blank_monitor.sv - XV blank-line transfer checker; XV_MONITOR_DWELL_CHECK_EN enables dwell checking
module xv_blank_monitor
  import xv_blank_monitor_pkg::*;
#(
  parameter int                     V_WIDTH          = 4,
  parameter int                     REG_WD           = 16,
  parameter logic [V_WIDTH-1:0]     XV_DEFAULT_VALUE = '0,
  parameter logic [8*V_WIDTH-1:0]   XV_SEQ           = '0,
  parameter int                     STATE_WIDTH      = 8,
  parameter int                     DWELL_TOL        = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [V_WIDTH-1:0] iv_xv,
  input  logic              i_blank_flag,
  input  logic [REG_WD-1:0] iv_blank_number,
  output logic [CNT_W-1:0]  ov_transfer_cnt,
  output logic              o_seq_done,
  output logic              o_count_ok,
  output logic              o_seq_err,
  output logic [1:0]        ov_err_code
);

  logic [V_WIDTH-1:0] xv_q, xv_q_d;
  logic               flag_q, flag_d;
  state_t             state, state_nxt;
  logic [2:0]         idx, idx_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [1:0]         err_code, err_nxt;

  logic               flag_rise, flag_fall, xv_changed;
  logic [V_WIDTH-1:0] phase1, exp_next;

  logic arm, done_evt, step_ok, complete, order_err_evt, phase_start, dwell_evt;

  assign flag_rise  = flag_q & ~flag_d;
  assign flag_fall  = ~flag_q & flag_d;
  assign xv_changed = (xv_q != xv_q_d);
  assign phase1     = XV_SEQ[V_WIDTH-1:0];
  assign idx_nxt    = idx + 3'd1;
  assign exp_next   = (idx == 3'(NUM_PHASES - 1)) ? XV_DEFAULT_VALUE
                                                  : XV_SEQ[int'(idx_nxt)*V_WIDTH +: V_WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if ((state != ST_IDLE) && flag_fall) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (flag_rise) state_nxt = ST_ARM;
        ST_ARM:     state_nxt = ST_WAIT_P1;
        ST_WAIT_P1: if (xv_q == phase1) state_nxt = ST_PHASE;
        ST_PHASE:   if (xv_changed && ((xv_q != exp_next) || (idx == 3'(NUM_PHASES - 1))))
                      state_nxt = ST_WAIT_P1;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // A window ending mid-transfer drops the partial transfer silently, but a completing step still counts.
  always_comb begin
    arm           = (state == ST_ARM);
    done_evt      = (state != ST_IDLE) && flag_fall;
    step_ok       = (state == ST_PHASE) && xv_changed && (xv_q == exp_next);
    complete      = step_ok && (idx == 3'(NUM_PHASES - 1));
    phase_start   = (state == ST_WAIT_P1) && (xv_q == phase1) && !done_evt;
    order_err_evt = !done_evt &&
                    (((state == ST_WAIT_P1) && (xv_q != phase1) && (xv_q != XV_DEFAULT_VALUE)) ||
                     ((state == ST_PHASE) && xv_changed && (xv_q != exp_next)));
  end

`ifdef XV_MONITOR_DWELL_CHECK_EN
  logic dwell_bad;

  xv_dwell_timer #(
    .STATE_WIDTH (STATE_WIDTH),
    .DWELL_TOL   (DWELL_TOL)
  ) u_dwell_timer (
    .clk           (clk),
    .reset         (reset),
    .restart       (phase_start | (step_ok & ~complete)),
    .run           ((state == ST_PHASE) & ~xv_changed),
    .clear         (arm),
    .out_of_window (dwell_bad)
  );

  assign dwell_evt = step_ok & ~done_evt & dwell_bad;
`else
  localparam int unused_dwell_cfg = STATE_WIDTH + DWELL_TOL;
  assign dwell_evt = 1'b0;
`endif

  always_comb begin
    cnt_nxt = cnt;
    err_nxt = err_code;
    if (arm) begin
      cnt_nxt = '0;
      err_nxt = '0;
    end else begin
      if (complete) cnt_nxt = sat_inc_cnt(cnt);
      err_nxt[ERR_ORDER_BIT] = err_code[ERR_ORDER_BIT] | order_err_evt;
      err_nxt[ERR_DWELL_BIT] = err_code[ERR_DWELL_BIT] | dwell_evt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xv_q       <= '0;
      xv_q_d     <= '0;
      flag_q     <= 1'b0;
      flag_d     <= 1'b0;
      idx        <= '0;
      cnt        <= '0;
      err_code   <= '0;
      o_seq_done <= 1'b0;
      o_count_ok <= 1'b0;
    end else begin
      xv_q       <= iv_xv;
      xv_q_d     <= xv_q;
      flag_q     <= i_blank_flag;
      flag_d     <= flag_q;
      cnt        <= cnt_nxt;
      err_code   <= err_nxt;
      o_seq_done <= done_evt;
      if (phase_start) begin
        idx <= '0;
      end else if (step_ok && !complete) begin
        idx <= idx_nxt;
      end
      if (done_evt) begin
        o_count_ok <= (REG_WD'(cnt_nxt) == iv_blank_number);
      end
    end
  end

  assign ov_transfer_cnt = cnt;
  assign ov_err_code     = err_code;
  assign o_seq_err       = |err_code;

endmodule

// File: tb/tb_xv_blank_monitor.sv
// tb/tb_xv_blank_monitor.sv - scoreboard bench for xv_blank_monitor
module tb_xv_blank_monitor;

  localparam logic [31:0] SEQ = 32'h98C46231;
  localparam logic [3:0]  DEF = 4'h0;
`ifdef XV_MONITOR_DWELL_CHECK_EN
  localparam logic [1:0]  LONG_CODE = 2'b10;
`else
  localparam logic [1:0]  LONG_CODE = 2'b00;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  iv_xv;
  logic        i_blank_flag;
  logic [15:0] iv_blank_number;
  logic [9:0]  ov_transfer_cnt;
  logic        o_seq_done, o_count_ok, o_seq_err;
  logic [1:0]  ov_err_code;

  xv_blank_monitor #(
    .V_WIDTH          (4),
    .REG_WD           (16),
    .XV_DEFAULT_VALUE (DEF),
    .XV_SEQ           (SEQ),
    .STATE_WIDTH      (8),
    .DWELL_TOL        (1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .iv_xv           (iv_xv),
    .i_blank_flag    (i_blank_flag),
    .iv_blank_number (iv_blank_number),
    .ov_transfer_cnt (ov_transfer_cnt),
    .o_seq_done      (o_seq_done),
    .o_count_ok      (o_count_ok),
    .o_seq_err       (o_seq_err),
    .ov_err_code     (ov_err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] cnt;
    logic       ok;
    logic       serr;
    logic [1:0] code;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic done_prev = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && o_seq_done) begin
      check("done_pulse_width", int'(done_prev), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("transfer_cnt", int'(ov_transfer_cnt), int'(mon_e.cnt));
        check("count_ok", int'(o_count_ok), int'(mon_e.ok));
        check("seq_err", int'(o_seq_err), int'(mon_e.serr));
        check("err_code", int'(ov_err_code), int'(mon_e.code));
      end
    end
    done_prev = o_seq_done;
  end

  function automatic logic [3:0] pc(input int k);
    return SEQ[k*4 +: 4];
  endfunction

  task automatic hold(input logic [3:0] code, input int n);
    iv_xv = code;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic transfer(input bit bad, input bit long4, input bit cut6, input bit fall_end);
    int d;
    logic [3:0] c;
    for (int k = 0; k < 8; k++) begin
      d = (k == 0) ? 7 : 8;
      c = pc(k);
      if (k == 3 && long4) d = 12;
      if (k == 2 && bad) c = pc(4);
      if (k == 5 && cut6) begin
        hold(c, 4);
        i_blank_flag = 1'b0;
        hold(c, 4);
      end else begin
        hold(c, d);
      end
    end
    if (fall_end) i_blank_flag = 1'b0;
    hold(DEF, 4);
  endtask

  task automatic window(input logic [15:0] blank, input int ntr, input int bad_tr,
                        input int long_tr, input int cut_tr, input bit fall_end,
                        input int e_cnt, input bit e_ok, input logic [1:0] e_code);
    exp_t e;
    e.cnt  = 10'(e_cnt);
    e.ok   = e_ok;
    e.code = e_code;
    e.serr = |e_code;
    exp_q.push_back(e);
    iv_blank_number = blank;
    i_blank_flag    = 1'b1;
    hold(DEF, 4);
    for (int t = 1; t <= ntr; t++)
      transfer(t == bad_tr, t == long_tr, t == cut_tr, fall_end && (t == ntr));
    i_blank_flag = 1'b0;
    hold(DEF, 6);
  endtask

  task automatic pulse_window(input logic [15:0] blank, input bit e_ok);
    exp_t e;
    e.cnt  = '0;
    e.ok   = e_ok;
    e.code = '0;
    e.serr = 1'b0;
    exp_q.push_back(e);
    iv_blank_number = blank;
    i_blank_flag    = 1'b1;
    hold(DEF, 1);
    i_blank_flag    = 1'b0;
    hold(DEF, 6);
  endtask

  initial begin
    int budget;
    reset = 1'b1;
    iv_xv = DEF;
    i_blank_flag = 1'b0;
    iv_blank_number = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cnt", int'(ov_transfer_cnt), 0);
    check("reset_done", int'(o_seq_done), 0);
    check("reset_ok", int'(o_count_ok), 0);
    check("reset_err", int'(ov_err_code), 0);
    reset = 1'b0;
    hold(DEF, 3);

    window(16'd4, 4, 0, 0, 0, 1'b0, 4, 1'b1, 2'b00);
    hold(DEF, 5);
    check("cnt_held_idle", int'(ov_transfer_cnt), 4);
    window(16'd5, 4, 0, 0, 0, 1'b0, 4, 1'b0, 2'b00);
    window(16'd4, 4, 2, 0, 0, 1'b0, 3, 1'b0, 2'b01);
    window(16'd4, 4, 0, 1, 0, 1'b0, 4, 1'b1, LONG_CODE);
    window(16'd2, 3, 0, 0, 3, 1'b0, 2, 1'b1, 2'b00);
    window(16'd4, 4, 0, 0, 0, 1'b1, 4, 1'b1, 2'b00);
    window(16'h0404, 4, 0, 0, 0, 1'b0, 4, 1'b0, 2'b00);
    pulse_window(16'd0, 1'b1);
    pulse_window(16'h0400, 1'b0);

    // Reset in the middle of a transfer: one transfer already counted, then everything discarded.
    iv_blank_number = 16'd2;
    i_blank_flag = 1'b1;
    hold(DEF, 4);
    transfer(1'b0, 1'b0, 1'b0, 1'b0);
    hold(pc(0), 7);
    hold(pc(1), 3);
    check("cnt_before_reset", int'(ov_transfer_cnt), 1);
    reset = 1'b1;
    i_blank_flag = 1'b0;
    #2;
    check("midreset_cnt", int'(ov_transfer_cnt), 0);
    check("midreset_ok", int'(o_count_ok), 0);
    check("midreset_seq_err", int'(o_seq_err), 0);
    check("midreset_err", int'(ov_err_code), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    hold(DEF, 8);
    check("post_reset_cnt", int'(ov_transfer_cnt), 0);

    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check("pending_expectations", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
